// File: rtl/master_out_pkg.sv
// Shared definitions for the master output stage: gain FSM states, gain format, soft-clip knee.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package master_out_pkg;

    typedef enum logic [1:0] {
        S_MUTED  = 2'd0,
        S_RAMP   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    // Gain is Q8 unsigned; 256 is exactly 1.0.
    localparam int GAIN_W     = 9;
    localparam int UNITY_GAIN = 256;

    // Soft-clip knee: magnitudes above this are compressed 4:1.
    localparam int SOFT_KNEE  = 24576;

    // Volume index 0..7 maps to (idx+1)/8 of unity; mute forces zero.
    function automatic logic [GAIN_W-1:0] vol_to_gain(input logic [2:0] vol, input logic mute);
        logic [GAIN_W-1:0] g;
        g = ({6'd0, vol} + 9'd1) << 5;
        return mute ? '0 : g;
    endfunction

endpackage

// File: rtl/master_out_stage_peak_meter.sv
// Peak meter: running max of |sample| over 2^WIN_LOG2 samples, log2 code of max registered at window end.
// Latency: o_peak registers on the same edge as the window's last sample is accepted.
// Backpressure: none; consumes every i_vld strobe.
//
// Ports: i_clk/i_rst clock and async active-high reset; i_vld/i_data sample strobe and signed
// sample; o_peak = index of highest set bit of window maximum plus one (0 = silence).
module peak_meter #(
    parameter int unsigned WIN_LOG2 = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vld,
    input  logic [15:0] i_data,
    output logic [3:0]  o_peak
);

    logic [WIN_LOG2-1:0] win_q, win_d;
    logic [15:0]         max_q, max_d;
    logic [3:0]          peak_q, peak_d;
    logic [15:0]         mag;
    logic [15:0]         cur;
    logic [3:0]          code;

    always_comb begin
        // |-32768| saturates to 32767 so the code never exceeds 15.
        if (i_data[15]) begin
            mag = (i_data == 16'h8000) ? 16'h7fff : -i_data;
        end else begin
            mag = i_data;
        end
        cur = (mag > max_q) ? mag : max_q;

        code = 4'd0;
        for (int b = 0; b < 15; b++) begin
            if (cur[b]) begin
                code = 4'(b + 1);
            end
        end
        if (cur[15]) begin
            code = 4'd15;
        end

        win_d  = win_q;
        max_d  = max_q;
        peak_d = peak_q;
        if (i_vld) begin
            win_d = win_q + 1'b1;
            if (&win_q) begin
                // Last sample of the window: publish and restart the maximum.
                peak_d = code;
                max_d  = '0;
            end else begin
                max_d = cur;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            win_q  <= '0;
            max_q  <= '0;
            peak_q <= '0;
        end else begin
            win_q  <= win_d;
            max_q  <= max_d;
            peak_q <= peak_d;
        end
    end

    assign o_peak = peak_q;

endmodule

// File: rtl/master_out_stage.sv
// Master output stage: click-free volume/mute ramp, optional soft clip, held clip flag, peak meter.
// Latency: 2 cycles i_valid -> o_valid; o_clip/o_muted/gain update 1 cycle after i_valid.
// Backpressure: none; fully pipelined, accepts i_valid every cycle.
//
// Ports: i_clk/i_rst (async active-high); i_valid/i_data signed sample in; i_volume 0..7 and
// i_mute sampled on i_valid; o_data/o_valid registered sample out; o_clip held clip indicator;
// o_peak 4-bit window peak code; o_muted high in S_MUTED.
// Build option: define MASTER_OUT_SOFTCLIP_EN to enable the 4:1 soft clip above the knee.
module master_out_stage
    import master_out_pkg::*;
#(
    parameter int unsigned RAMP_STEP    = 1,
    parameter logic [15:0] CLIP_THRESH  = 16'd32000,
    parameter int unsigned HOLD_SAMPLES = 4800,
    parameter int unsigned WIN_LOG2     = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    input  logic [2:0]  i_volume,
    input  logic        i_mute,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_clip,
    output logic [3:0]  o_peak,
    output logic        o_muted
);

    localparam logic [GAIN_W-1:0] STEP   = GAIN_W'(RAMP_STEP);
    localparam int                HOLD_W = $clog2(HOLD_SAMPLES + 1);
    localparam logic [HOLD_W-1:0] HOLD   = HOLD_W'(HOLD_SAMPLES);

    // ---------------- gain ramp and FSM ----------------
    state_t            state_q, state_d;
    logic [GAIN_W-1:0] g_t;
    logic [GAIN_W-1:0] g_r_q, g_r_d;

    always_comb begin
        g_t     = vol_to_gain(i_volume, i_mute);
        g_r_d   = g_r_q;
        state_d = state_q;
        if (i_valid) begin
            // Step toward target, clamped so the gain lands exactly on it.
            if (g_r_q < g_t) begin
                g_r_d = ((g_t - g_r_q) > STEP) ? g_r_q + STEP : g_t;
            end else if (g_r_q > g_t) begin
                g_r_d = ((g_r_q - g_t) > STEP) ? g_r_q - STEP : g_t;
            end

            // Transitions look at the post-step gain so a large step can settle in one sample.
            case (state_q)
                S_MUTED: begin
                    if (g_t != '0) begin
                        state_d = (g_r_d == g_t) ? S_ACTIVE : S_RAMP;
                    end
                end
                S_RAMP: begin
                    if (g_r_d == g_t) begin
                        state_d = (g_t == '0) ? S_MUTED : S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (g_t != g_r_q) begin
                        if (g_r_d != g_t) begin
                            state_d = S_RAMP;
                        end else if (g_t == '0) begin
                            state_d = S_MUTED;
                        end
                    end
                end
                default: state_d = S_MUTED;
            endcase
        end
    end

    // ---------------- clip detect and hold ----------------
    logic [15:0]       abs_in;
    logic              is_clip;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              clip_q, clip_d;

    always_comb begin
        if (i_data[15]) begin
            abs_in = (i_data == 16'h8000) ? 16'h7fff : -i_data;
        end else begin
            abs_in = i_data;
        end
        is_clip = (abs_in >= CLIP_THRESH);

        hold_d = hold_q;
        clip_d = clip_q;
        if (i_valid) begin
            if (is_clip) begin
                hold_d = HOLD;
                clip_d = 1'b1;
            end else begin
                // Flag stays up while the count before this sample was nonzero, giving
                // exactly HOLD_SAMPLES further samples of indication.
                clip_d = (hold_q != '0);
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end
            end
        end
    end

    // ---------------- stage 1: multiply ----------------
    logic signed [25:0] prod_q, prod_d;
    logic               vld1_q, vld1_d;

    always_comb begin
        vld1_d = i_valid;
        prod_d = prod_q;
        if (i_valid) begin
            // Pre-step gain is used for this sample.
            prod_d = 26'(signed'(i_data)) * 26'(signed'({1'b0, g_r_q}));
        end
    end

    // ---------------- stage 2: shift, soft clip, saturate ----------------
    logic signed [25:0] sh;
    logic signed [25:0] ysc;
    logic [15:0]        sat;
    logic [15:0]        o_data_q, o_data_d;
    logic               o_valid_q, o_valid_d;
`ifdef MASTER_OUT_SOFTCLIP_EN
    localparam logic [25:0] KNEE = 26'(SOFT_KNEE);
    logic [25:0]        ay;
    logic [25:0]        mag;
`endif

    always_comb begin
        sh  = prod_q >>> 8;
        ysc = sh;
`ifdef MASTER_OUT_SOFTCLIP_EN
        ay  = sh[25] ? 26'(-sh) : 26'(sh);
        mag = ay;
        if (ay > KNEE) begin
            mag = KNEE + ((ay - KNEE) >> 2);
            ysc = sh[25] ? -$signed(mag) : $signed(mag);
        end
`endif
        if (ysc > 26'sd32767) begin
            sat = 16'h7fff;
        end else if (ysc < -26'sd32768) begin
            sat = 16'h8000;
        end else begin
            sat = ysc[15:0];
        end

        o_valid_d = vld1_q;
        o_data_d  = vld1_q ? sat : o_data_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_MUTED;
            g_r_q     <= '0;
            hold_q    <= '0;
            clip_q    <= 1'b0;
            prod_q    <= '0;
            vld1_q    <= 1'b0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_r_q     <= g_r_d;
            hold_q    <= hold_d;
            clip_q    <= clip_d;
            prod_q    <= prod_d;
            vld1_q    <= vld1_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
        end
    end

    // Meter sees the stage-2 result so o_peak lands together with the window's last o_data.
    peak_meter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_peak_meter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_vld  (vld1_q),
        .i_data (sat),
        .o_peak (o_peak)
    );

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_clip  = clip_q;
    assign o_muted = (state_q == S_MUTED);

endmodule

// File: tb/tb_master_out_stage.sv
// Randomized scoreboard bench for master_out_stage with a behavioural reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_master_out_stage;

    localparam int STEP   = 3;
    localparam int HOLD   = 4;
    localparam int WINL   = 2;
    localparam int WIN    = 1 << WINL;
    localparam int THRESH = 32000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [15:0] i_data;
    logic [2:0]  i_volume;
    logic        i_mute;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_clip;
    logic [3:0]  o_peak;
    logic        o_muted;

    always #5 i_clk = ~i_clk;

    master_out_stage #(
        .RAMP_STEP    (STEP),
        .CLIP_THRESH  (16'd32000),
        .HOLD_SAMPLES (HOLD),
        .WIN_LOG2     (WINL)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .i_volume (i_volume),
        .i_mute   (i_mute),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_clip   (o_clip),
        .o_peak   (o_peak),
        .o_muted  (o_muted)
    );

    typedef struct { int data; int peak; } out_t;
    typedef struct { bit clip; bit muted; } side_t;
    out_t  q_out[$];
    side_t q_side[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state (plain integers).
    int m_gain;
    int m_since;
    bit m_seen;
    int m_win_idx;
    int m_win_max;
    int m_peak;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_gain    = 0;
        m_since   = 0;
        m_seen    = 0;
        m_win_idx = 0;
        m_win_max = 0;
        m_peak    = 0;
    endtask

    function automatic int model_out(input int d, input int g);
        int y;
        int a;
        y = (d * g) >>> 8;
`ifdef MASTER_OUT_SOFTCLIP_EN
        a = iabs(y);
        if (a > 24576) begin
            a = 24576 + (a - 24576) / 4;
            y = (y < 0) ? -a : a;
        end
`endif
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    // Issue one sample at the next falling edge and push its expected results.
    task automatic send(input int d, input int vol, input bit mute);
        int    gt;
        int    y;
        int    a;
        out_t  o;
        side_t s;
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_data   = d[15:0];
        i_volume = vol[2:0];
        i_mute   = mute;

        gt = mute ? 0 : (vol + 1) * 32;
        y  = model_out(d, m_gain);

        a = (y == -32768) ? 32767 : iabs(y);
        if (a > m_win_max) m_win_max = a;
        m_win_idx++;
        if (m_win_idx == WIN) begin
            m_peak    = $clog2(m_win_max + 1);
            m_win_idx = 0;
            m_win_max = 0;
        end
        o.data = y;
        o.peak = m_peak;
        q_out.push_back(o);

        a = (d == -32768) ? 32767 : iabs(d);
        if (a >= THRESH) begin
            m_seen  = 1;
            m_since = 0;
        end else begin
            m_since++;
        end

        if (m_gain < gt) m_gain = (m_gain + STEP > gt) ? gt : m_gain + STEP;
        else if (m_gain > gt) m_gain = (m_gain - STEP < gt) ? gt : m_gain - STEP;

        s.clip  = m_seen && (m_since <= HOLD);
        s.muted = (m_gain == 0) && (gt == 0);
        q_side.push_back(s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while ((q_out.size() != 0 || q_side.size() != 0) && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_timeout", q_out.size() + q_side.size(), 0);
    endtask

    function automatic int pick_data();
        logic [15:0] r;
        int t;
        case ($urandom_range(0, 7))
            0: return 32767;
            1: return -32768;
            2: return 0;
            3: begin
                t = int'($urandom_range(31990, 32010));
                return ($urandom_range(0, 1) == 1) ? -t : t;
            end
            4: return int'($urandom_range(0, 300)) - 150;
            default: begin
                r = 16'($urandom);
                return int'($signed(r));
            end
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_o_data"},  int'(o_data), 0);
        check({tag, "_o_valid"}, int'(o_valid), 0);
        check({tag, "_o_clip"},  int'(o_clip), 0);
        check({tag, "_o_peak"},  int'(o_peak), 0);
        check({tag, "_o_muted"}, int'(o_muted), 1);
    endtask

    // Pipeline of "sample accepted" marks to know when side outputs and o_valid are due.
    logic v1, v2;
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= i_valid;
            v2 <= v1;
        end
    end

    // Monitor: compares DUT outputs to the queued expectations.
    always @(negedge i_clk) begin
        out_t  o;
        side_t s;
        if (!i_rst) begin
            if (v1) begin
                if (q_side.size() == 0) begin
                    check("side_queue_empty", 1, 0);
                end else begin
                    s = q_side.pop_front();
                    check("o_clip", int'(o_clip), int'(s.clip));
                    check("o_muted", int'(o_muted), int'(s.muted));
                end
            end
            if (o_valid || v2) begin
                check("o_valid_latency", int'(o_valid), int'(v2));
            end
            if (o_valid) begin
                if (q_out.size() == 0) begin
                    check("out_queue_empty", 1, 0);
                end else begin
                    o = q_out.pop_front();
                    check("o_data", int'($signed(o_data)), o.data);
                    check("o_peak", int'(o_peak), o.peak);
                end
            end
        end
    end

    initial begin
        int vol;
        bit mute;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_volume = '0;
        i_mute   = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_rst = 1'b0;

        // Fade in from silence at full volume.
        for (int i = 0; i < 100; i++) begin
            send(10000, 7, 1'b0);
            idle($urandom_range(0, 2));
        end

        // Volume 3 (gain 128) with a negative input.
        for (int i = 0; i < 80; i++) begin
            send(-20000, 3, 1'b0);
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        // Random traffic with occasional retargeting and clip-range samples.
        vol  = 7;
        mute = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) vol = int'($urandom_range(0, 7));
            if ($urandom_range(0, 149) == 0) mute = ~mute;
            send(pick_data(), vol, mute);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        // Mute to silence, then a few all-zero windows.
        for (int i = 0; i < 120; i++) send(pick_data(), vol, 1'b1);
        for (int i = 0; i < 3 * WIN; i++) send(0, vol, 1'b1);
        drain();

        // Unmute at unity and hold a clip-level tone through several windows.
        for (int i = 0; i < 120; i++) send(32767, 7, 1'b0);
        for (int i = 0; i < 2 * WIN; i++) send(-32768, 7, 1'b0);
        drain();

        // Asynchronous reset mid-cycle.
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 40; i++) send(pick_data(), 7, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
